snake_body_store: RTL and testbench

- Parametrised snake body engine for the 160x120 VGA snake game.
- Holds up to MAX_LEN segment origins in a circular register buffer with variable length.
- Moves the snake one segment pitch per step request, optionally growing.
- Detects wall and self collisions before committing a step.
- Provides an indexed read port for the draw/erase FSM, plus the vacated tail position for erase.

---
 rtl/snake_body_store.sv | 271 +++++++++++++++++++++++++++
 tb/tb_snake_body_store.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/snake_body_store.sv
// Snake body engine for the 160x120 VGA snake game.
// Keeps up to MAX_LEN segment origins in a circular register buffer addressed
// through a head pointer. Each step computes the new head, screens it against
// the walls and the body, then commits it.
// Build option: define SNAKE_WRAP_EN to wrap at the screen edges instead of
// raising the wall fault.
module snake_body_store #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int SEG      = 10,
  parameter int X_INIT   = 80,
  parameter int Y_INIT   = 60,
  parameter int X_LIM    = 150,
  parameter int Y_LIM    = 110
) (
  input  logic                       CLOCK_50,
  input  logic                       Resetn,
  input  logic                       init,
  input  logic                       step,
  input  logic [1:0]                 dir,
  input  logic                       grow,
  output logic                       busy,
  output logic                       done,
  output logic                       collide,
  output logic                       wall,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic [XW-1:0]              head_x,
  output logic [YW-1:0]              head_y,
  output logic [XW-1:0]              tail_x,
  output logic [YW-1:0]              tail_y,
  output logic                       tail_vld,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [XW-1:0]              rd_x,
  output logic [YW-1:0]              rd_y
);

  localparam int IW = $clog2(MAX_LEN);

  typedef logic [IW-1:0]        idx_t;
  typedef logic [IW:0]          len_t;
  typedef logic [XW-1:0]        cx_t;
  typedef logic [YW-1:0]        cy_t;
  typedef logic signed [XW:0]   sx_t;
  typedef logic signed [YW:0]   sy_t;

  localparam logic [1:0] D_RIGHT = 2'b00;
  localparam logic [1:0] D_DOWN  = 2'b01;
  localparam logic [1:0] D_UP    = 2'b10;
  localparam logic [1:0] D_LEFT  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_SCAN, S_COMMIT, S_DONE} state_t;
  state_t state, state_nx;

  cx_t        seg_x [MAX_LEN];
  cy_t        seg_y [MAX_LEN];
  idx_t       hp, k;
  logic [1:0] last_dir, dir_q, eff_dir;
  logic       grow_q, grow_eff;
  cx_t        nx_q;
  cy_t        ny_q;
  len_t       lc;
  idx_t       scan_slot, tail_slot, new_slot, rd_slot;
  sx_t        hx_s, nx_s;
  sy_t        hy_s, ny_s;
  cx_t        nx_fix;
  cy_t        ny_fix;
  logic       wall_hit, seg_hit, scan_last;
  logic       accept, set_coll, commit;

  // Initial body: a vertical column heading up, head on top.
  function automatic cx_t init_x(input int i);
    return (i < INIT_LEN) ? cx_t'(X_INIT) : '0;
  endfunction

  function automatic cy_t init_y(input int i);
    return (i < INIT_LEN) ? cy_t'(Y_INIT + i * SEG) : '0;
  endfunction

  function automatic logic x_out(input sx_t v);
    return v[XW] || (v > sx_t'(X_LIM));
  endfunction

  function automatic logic y_out(input sy_t v);
    return v[YW] || (v > sy_t'(Y_LIM));
  endfunction

`ifdef SNAKE_WRAP_EN
  // Negative coordinates reappear at the far edge, overflow reappears at 0.
  function automatic cx_t wrap_x(input sx_t v);
    if (v[XW])          return cx_t'(X_LIM);
    else if (x_out(v))  return '0;
    else                return v[XW-1:0];
  endfunction

  function automatic cy_t wrap_y(input sy_t v);
    if (v[YW])          return cy_t'(Y_LIM);
    else if (y_out(v))  return '0;
    else                return v[YW-1:0];
  endfunction
`endif

  assign head_x    = seg_x[hp];
  assign head_y    = seg_y[hp];
  assign scan_slot = hp + k;
  assign tail_slot = hp + idx_t'(length - len_t'(1));
  assign new_slot  = hp - idx_t'(1);
  assign rd_slot   = hp + rd_idx;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // New-head arithmetic, one extra bit so a move past 0 shows up as negative.
  always_comb begin
    eff_dir = ((dir_q ^ last_dir) == 2'b11) ? last_dir : dir_q;
    hx_s    = sx_t'({1'b0, head_x});
    hy_s    = sy_t'({1'b0, head_y});
    nx_s    = hx_s;
    ny_s    = hy_s;
    case (eff_dir)
      D_RIGHT: nx_s = hx_s + sx_t'(SEG);
      D_DOWN:  ny_s = hy_s + sy_t'(SEG);
      D_UP:    ny_s = hy_s - sy_t'(SEG);
      D_LEFT:  nx_s = hx_s - sx_t'(SEG);
      default: nx_s = hx_s;
    endcase
`ifdef SNAKE_WRAP_EN
    nx_fix   = wrap_x(nx_s);
    ny_fix   = wrap_y(ny_s);
    wall_hit = 1'b0;
`else
    nx_fix   = nx_s[XW-1:0];
    ny_fix   = ny_s[YW-1:0];
    wall_hit = x_out(nx_s) || y_out(ny_s);
`endif
  end

  // Scan bookkeeping: Lc is the body length that will survive the move.
  always_comb begin
    grow_eff  = grow_q && (length < len_t'(MAX_LEN));
    lc        = grow_eff ? length : (length - len_t'(1));
    seg_hit   = (seg_x[scan_slot] == nx_q) && (seg_y[scan_slot] == ny_q);
    scan_last = ({1'b0, k} == (lc - len_t'(1)));
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state and control strobes; init overrides everything.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    set_coll = 1'b0;
    commit   = 1'b0;
    if (init) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (step && !collide && !wall) begin
            accept   = 1'b1;
            state_nx = S_CALC;
          end
        end
        S_CALC: state_nx = wall_hit ? S_DONE : S_SCAN;
        S_SCAN: begin
          if (lc <= len_t'(1)) begin
            state_nx = S_COMMIT;
          end else if (seg_hit) begin
            set_coll = 1'b1;
            state_nx = S_DONE;
          end else if (scan_last) begin
            state_nx = S_COMMIT;
          end
        end
        S_COMMIT: begin
          commit   = 1'b1;
          state_nx = S_DONE;
        end
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Segment buffer and head pointer; a commit pushes the new head in front.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= init_y(i);
      end
      hp <= '0;
    end else if (init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= init_y(i);
      end
      hp <= '0;
    end else if (commit) begin
      seg_x[new_slot] <= nx_q;
      seg_y[new_slot] <= ny_q;
      hp              <= new_slot;
    end
  end

  // Step context, fault flags, length/tail tracking and the read port.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      dir_q    <= D_UP;
      grow_q   <= 1'b0;
      last_dir <= D_UP;
      nx_q     <= '0;
      ny_q     <= '0;
      k        <= '0;
      collide  <= 1'b0;
      wall     <= 1'b0;
      length   <= len_t'(INIT_LEN);
      tail_x   <= '0;
      tail_y   <= '0;
      tail_vld <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
    end else if (init) begin
      dir_q    <= D_UP;
      grow_q   <= 1'b0;
      last_dir <= D_UP;
      nx_q     <= '0;
      ny_q     <= '0;
      k        <= '0;
      collide  <= 1'b0;
      wall     <= 1'b0;
      length   <= len_t'(INIT_LEN);
      tail_x   <= '0;
      tail_y   <= '0;
      tail_vld <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
    end else begin
      rd_x <= seg_x[rd_slot];
      rd_y <= seg_y[rd_slot];
      if (accept) begin
        dir_q  <= dir;
        grow_q <= grow;
      end
      if (state == S_CALC) begin
        nx_q <= nx_fix;
        ny_q <= ny_fix;
        k    <= idx_t'(1);
        if (wall_hit) wall <= 1'b1;
      end
      if (state == S_SCAN) k <= k + idx_t'(1);
      if (set_coll) collide <= 1'b1;
      if (commit) begin
        last_dir <= eff_dir;
        if (grow_eff) begin
          length   <= length + len_t'(1);
          tail_vld <= 1'b0;
        end else begin
          tail_x   <= seg_x[tail_slot];
          tail_y   <= seg_y[tail_slot];
          tail_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_body_store.sv
// Directed bench for snake_body_store (default build, walls fault).
module tb_snake_body_store;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn;
  logic       init, step, grow;
  logic [1:0] dir;
  logic       busy, done, collide, wall, tail_vld;
  logic [5:0] length;
  logic [7:0] head_x, tail_x, rd_x;
  logic [6:0] head_y, tail_y, rd_y;
  logic [4:0] rd_idx;

  int nerr = 0;
  int nchk = 0;

  snake_body_store dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .init(init), .step(step),
    .dir(dir), .grow(grow), .busy(busy), .done(done), .collide(collide),
    .wall(wall), .length(length), .head_x(head_x), .head_y(head_y),
    .tail_x(tail_x), .tail_y(tail_y), .tail_vld(tail_vld),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one step; lat counts edges from the sampling edge to the edge
  // after which done is seen (the sampling edge counts as 1); -1 on timeout.
  task automatic do_step(input logic [1:0] d, input logic g, output int lat);
    step = 1'b1; dir = d; grow = g;
    @(posedge CLOCK_50); #1;
    step = 1'b0; grow = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge CLOCK_50); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    else begin
      @(posedge CLOCK_50); #1;
    end
  endtask

  task automatic do_init();
    init = 1'b1;
    @(posedge CLOCK_50); #1;
    init = 1'b0;
  endtask

  task automatic rd(input int i, output logic [7:0] x, output logic [6:0] y);
    rd_idx = 5'(i);
    @(posedge CLOCK_50); #1;
    x = rd_x; y = rd_y;
  endtask

  // Pulse step and report whether the engine reacted at all.
  task automatic poke_step(output logic seen);
    step = 1'b1; dir = 2'b10;
    @(posedge CLOCK_50); #1;
    step = 1'b0;
    seen = busy;
    repeat (10) begin
      @(posedge CLOCK_50); #1;
      if (busy || done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] x; logic [6:0] y;
    Resetn = 1'b0; init = 1'b0; step = 1'b0; grow = 1'b0; dir = 2'b00; rd_idx = '0;
    repeat (3) @(posedge CLOCK_50);
    #1 Resetn = 1'b1;
    nchk++; if (length !== 6'd4) begin nerr++; $display("FAIL reset_length got=%0d want=4", length); end
    nchk++; if ({busy, done, collide, wall, tail_vld} !== 5'b0) begin nerr++; $display("FAIL reset_flags got=%b want=00000", {busy, done, collide, wall, tail_vld}); end
    nchk++; if ({tail_x, tail_y, rd_x, rd_y} !== '0) begin nerr++; $display("FAIL reset_tail_rd got=%0d,%0d,%0d,%0d want=0", tail_x, tail_y, rd_x, rd_y); end
    for (int i = 0; i < 4; i++) begin
      rd(i, x, y);
      nchk++; if (x !== 8'd80 || y !== 7'(60 + 10 * i)) begin nerr++; $display("FAIL reset_seg%0d got=(%0d,%0d) want=(80,%0d)", i, x, y, 60 + 10 * i); end
    end
    rd(4, x, y);
    nchk++; if (x !== 8'd0 || y !== 7'd0) begin nerr++; $display("FAIL reset_seg4 got=(%0d,%0d) want=(0,0)", x, y); end
  endtask

  task automatic test_step_right();
    int lat; logic [7:0] x; logic [6:0] y;
    do_init();
    do_step(2'b00, 1'b0, lat);
    nchk++; if (lat !== 5) begin nerr++; $display("FAIL right_latency got=%0d want=5", lat); end
    nchk++; if (done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL right_done_pulse got=done%b busy%b want=0 0", done, busy); end
    nchk++; if (head_x !== 8'd90 || head_y !== 7'd60) begin nerr++; $display("FAIL right_head got=(%0d,%0d) want=(90,60)", head_x, head_y); end
    nchk++; if (tail_x !== 8'd80 || tail_y !== 7'd90 || tail_vld !== 1'b1) begin nerr++; $display("FAIL right_tail got=(%0d,%0d) v%b want=(80,90) v1", tail_x, tail_y, tail_vld); end
    nchk++; if (length !== 6'd4) begin nerr++; $display("FAIL right_length got=%0d want=4", length); end
    rd(1, x, y);
    nchk++; if (x !== 8'd80 || y !== 7'd60) begin nerr++; $display("FAIL right_seg1 got=(%0d,%0d) want=(80,60)", x, y); end
    rd(3, x, y);
    nchk++; if (x !== 8'd80 || y !== 7'd80) begin nerr++; $display("FAIL right_seg3 got=(%0d,%0d) want=(80,80)", x, y); end
  endtask

  task automatic test_reverse();
    int lat;
    do_init();
    do_step(2'b01, 1'b0, lat);
    nchk++; if (head_x !== 8'd80 || head_y !== 7'd50) begin nerr++; $display("FAIL reverse_head got=(%0d,%0d) want=(80,50)", head_x, head_y); end
    nchk++; if (collide !== 1'b0 || lat !== 5) begin nerr++; $display("FAIL reverse_coll_lat got=c%b lat%0d want=c0 lat5", collide, lat); end
  endtask

  task automatic test_wall();
    int lat; logic seen;
    do_init();
    for (int n = 0; n < 6; n++) do_step(2'b10, 1'b0, lat);
    nchk++; if (head_x !== 8'd80 || head_y !== 7'd0 || wall !== 1'b0) begin nerr++; $display("FAIL wall_edge_commit got=(%0d,%0d) w%b want=(80,0) w0", head_x, head_y, wall); end
    do_step(2'b10, 1'b0, lat);
    nchk++; if (lat !== 2) begin nerr++; $display("FAIL wall_latency got=%0d want=2", lat); end
    nchk++; if (wall !== 1'b1 || head_y !== 7'd0 || length !== 6'd4) begin nerr++; $display("FAIL wall_fault got=w%b y%0d len%0d want=w1 y0 len4", wall, head_y, length); end
    poke_step(seen);
    nchk++; if (seen !== 1'b0) begin nerr++; $display("FAIL wall_step_ignored got=%b want=0", seen); end
    do_init();
    nchk++; if (wall !== 1'b0 || head_x !== 8'd80 || head_y !== 7'd60) begin nerr++; $display("FAIL wall_init_clear got=w%b (%0d,%0d) want=w0 (80,60)", wall, head_x, head_y); end
  endtask

  task automatic test_collide();
    int lat; logic seen;
    do_init();
    do_step(2'b00, 1'b1, lat);
    nchk++; if (lat !== 6 || length !== 6'd5 || tail_vld !== 1'b0) begin nerr++; $display("FAIL grow1 got=lat%0d len%0d v%b want=lat6 len5 v0", lat, length, tail_vld); end
    do_step(2'b10, 1'b1, lat);
    do_step(2'b11, 1'b1, lat);
    nchk++; if (lat !== 8 || length !== 6'd7) begin nerr++; $display("FAIL grow3 got=lat%0d len%0d want=lat8 len7", lat, length); end
    nchk++; if (head_x !== 8'd80 || head_y !== 7'd50) begin nerr++; $display("FAIL grow3_head got=(%0d,%0d) want=(80,50)", head_x, head_y); end
    do_step(2'b01, 1'b0, lat);
    nchk++; if (collide !== 1'b1 || lat !== 5) begin nerr++; $display("FAIL collide_flag got=c%b lat%0d want=c1 lat5", collide, lat); end
    nchk++; if (head_x !== 8'd80 || head_y !== 7'd50 || length !== 6'd7) begin nerr++; $display("FAIL collide_nocommit got=(%0d,%0d) len%0d want=(80,50) len7", head_x, head_y, length); end
    poke_step(seen);
    nchk++; if (seen !== 1'b0) begin nerr++; $display("FAIL collide_step_ignored got=%b want=0", seen); end
    do_init();
    nchk++; if (collide !== 1'b0 || length !== 6'd4) begin nerr++; $display("FAIL collide_init_clear got=c%b len%0d want=c0 len4", collide, length); end
  endtask

  task automatic test_init_abort();
    step = 1'b1; dir = 2'b00; grow = 1'b0;
    @(posedge CLOCK_50); #1;
    step = 1'b0;
    @(posedge CLOCK_50); #1;
    do_init();
    nchk++; if (busy !== 1'b0 || head_x !== 8'd80 || head_y !== 7'd60) begin nerr++; $display("FAIL init_abort got=b%b (%0d,%0d) want=b0 (80,60)", busy, head_x, head_y); end
    repeat (6) @(posedge CLOCK_50);
    #1;
    nchk++; if (head_x !== 8'd80 || tail_vld !== 1'b0) begin nerr++; $display("FAIL init_abort_late got=x%0d v%b want=x80 v0", head_x, tail_vld); end
  endtask

  // Grow on every step along the outer loop of the screen until capacity.
  task automatic test_saturate();
    int lat, elat, ex, ey, elen, lcm;
    logic [1:0] d;
    do_init();
    ex = 80; ey = 60; elen = 4;
    for (int n = 1; n <= 40; n++) begin
      if (n <= 6)       d = 2'b10;
      else if (n <= 13) d = 2'b00;
      else if (n <= 24) d = 2'b01;
      else if (n <= 39) d = 2'b11;
      else              d = 2'b10;
      case (d)
        2'b00: ex += 10;
        2'b01: ey += 10;
        2'b10: ey -= 10;
        default: ex -= 10;
      endcase
      lcm  = (elen < 32) ? elen : elen - 1;
      elat = 1 + ((lcm - 1 > 1) ? lcm - 1 : 1) + 2;
      if (elen < 32) elen++;
      do_step(d, 1'b1, lat);
      nchk++; if (head_x !== 8'(ex) || head_y !== 7'(ey)) begin nerr++; $display("FAIL sat_head%0d got=(%0d,%0d) want=(%0d,%0d)", n, head_x, head_y, ex, ey); end
      nchk++; if (length !== 6'(elen)) begin nerr++; $display("FAIL sat_length%0d got=%0d want=%0d", n, length, elen); end
      nchk++; if (tail_vld !== (n > 28)) begin nerr++; $display("FAIL sat_tail_vld%0d got=%b want=%b", n, tail_vld, (n > 28)); end
      nchk++; if (lat !== elat) begin nerr++; $display("FAIL sat_latency%0d got=%0d want=%0d", n, lat, elat); end
    end
    nchk++; if (collide !== 1'b0 || wall !== 1'b0) begin nerr++; $display("FAIL sat_faults got=c%b w%b want=c0 w0", collide, wall); end
  endtask

  initial begin
    test_reset();
    test_step_right();
    test_reverse();
    test_wall();
    test_collide();
    test_init_abort();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
